// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: register file, immediate/control decode,
// load-use stall request and the ID/EX pipeline register.
module id_stage #(
  parameter bit REG_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src_imm,
  output logic        ex_alu_src_pc,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_valid,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [31:0] r_rf [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_funct3;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic [3:0]  w_alu_op;
  logic        w_src_imm, w_src_pc, w_mem_read, w_mem_write, w_reg_write;
  logic        w_mem_to_reg, w_branch, w_jump, w_illegal;
  logic        w_use_rs1, w_use_rs2, w_bubble, w_hazard;

  // instr[30] selects SUB (OP only) and the arithmetic right shift (OP and OP-IMM)
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt,
                                                 input logic is_op);
    case (f3)
      3'b000:  alu_from_funct3 = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct3 = ALU_SLL;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b011:  alu_from_funct3 = ALU_SLTU;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b101:  alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct3 = ALU_OR;
      default: alu_from_funct3 = ALU_AND;
    endcase
  endfunction

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_funct3 = if_instr[14:12];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];
  assign w_bubble = (if_instr == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                      (REG_BYPASS && wb_we && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                      (REG_BYPASS && wb_we && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2];

  assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
  assign w_imm_u = {if_instr[31:12], 12'd0};
  assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

  always_comb begin
    w_imm        = 32'd0;
    w_alu_op     = ALU_ADD;
    w_src_imm    = 1'b0;
    w_src_pc     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_illegal    = 1'b0;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_imm = w_imm_u; w_alu_op = ALU_PASSB; w_src_imm = 1'b1; w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm = w_imm_u; w_src_pc = 1'b1; w_src_imm = 1'b1; w_reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_imm = w_imm_j; w_jump = 1'b1; w_reg_write = 1'b1;
      end
      OPC_JALR: begin
        w_imm = w_imm_i; w_jump = 1'b1; w_reg_write = 1'b1; w_src_imm = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b; w_alu_op = ALU_SUB; w_branch = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        w_imm = w_imm_i; w_src_imm = 1'b1; w_mem_read = 1'b1; w_mem_to_reg = 1'b1;
        w_reg_write = 1'b1; w_use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_imm = w_imm_s; w_src_imm = 1'b1; w_mem_write = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        w_imm = w_imm_i; w_alu_op = alu_from_funct3(w_funct3, if_instr[30], 1'b0);
        w_src_imm = 1'b1; w_reg_write = 1'b1; w_use_rs1 = 1'b1;
      end
      OPC_OP: begin
        w_alu_op = alu_from_funct3(w_funct3, if_instr[30], 1'b1);
        w_reg_write = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Only source fields the format really reads may raise a load-use hazard
  assign w_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((w_use_rs1 && (ex_rd == w_rs1)) || (w_use_rs2 && (ex_rd == w_rs2)));
  assign stall    = w_hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || stall || w_bubble) begin
      ex_pc          <= 32'd0;
      ex_rs1_data    <= 32'd0;
      ex_rs2_data    <= 32'd0;
      ex_imm         <= 32'd0;
      ex_rs1         <= 5'd0;
      ex_rs2         <= 5'd0;
      ex_rd          <= 5'd0;
      ex_funct3      <= 3'd0;
      ex_alu_op      <= 4'd0;
      ex_alu_src_imm <= 1'b0;
      ex_alu_src_pc  <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_valid       <= 1'b0;
      ex_illegal     <= 1'b0;
    end else begin
      ex_pc          <= if_pc;
      ex_rs1_data    <= w_rs1_data;
      ex_rs2_data    <= w_rs2_data;
      ex_imm         <= w_imm;
      ex_rs1         <= w_rs1;
      ex_rs2         <= w_rs2;
      ex_rd          <= w_reg_write ? w_rd : 5'd0;
      ex_funct3      <= w_funct3;
      ex_alu_op      <= w_alu_op;
      ex_alu_src_imm <= w_src_imm;
      ex_alu_src_pc  <= w_src_pc;
      ex_mem_read    <= w_mem_read;
      ex_mem_write   <= w_mem_write;
      ex_reg_write   <= w_reg_write;
      ex_mem_to_reg  <= w_mem_to_reg;
      ex_branch      <= w_branch;
      ex_jump        <= w_jump;
      ex_valid       <= 1'b1;
      ex_illegal     <= w_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage: vector table, directed hazard
// sequences and a randomized run against a behavioural decode model.
module tb_id_stage;

  logic        clk, rst, flush, wb_we, stall;
  logic [4:0]  wb_rd;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write;
  logic ex_mem_to_reg, ex_branch, ex_jump, ex_valid, ex_illegal;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic si, sp, mr, mw, rw, m2r, br, jp, valid, ill;
  } ex_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  ctl;   // {src_imm, src_pc, mem_read, mem_write, reg_write, mem_to_reg, branch, jump}
    logic [4:0]  rd;
    logic        valid;
    logic        ill;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl_rf [32];

  function automatic ex_t dut_ex();
    ex_t d;
    d = '{ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op,
          ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write,
          ex_mem_to_reg, ex_branch, ex_jump, ex_valid, ex_illegal};
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    ex_t d;
    d = dut_ex();
    n_cmp++;
    if (d !== '0) begin
      n_bad++;
      $display("FAIL %s: got %h required all zero", name, d);
    end
  endtask

  // Controls/valid/illegal/rd always; data fields only for a legal issued instruction
  task automatic cmp_ex(input string name, input ex_t e);
    ex_t d;
    d = dut_ex();
    n_cmp++;
    if ({d.alu, d.si, d.sp, d.mr, d.mw, d.rw, d.m2r, d.br, d.jp, d.valid, d.ill, d.rd} !==
        {e.alu, e.si, e.sp, e.mr, e.mw, e.rw, e.m2r, e.br, e.jp, e.valid, e.ill, e.rd}) begin
      n_bad++;
      $display("FAIL %s ctl: got %h required %h", name,
               {d.alu, d.si, d.sp, d.mr, d.mw, d.rw, d.m2r, d.br, d.jp, d.valid, d.ill, d.rd},
               {e.alu, e.si, e.sp, e.mr, e.mw, e.rw, e.m2r, e.br, e.jp, e.valid, e.ill, e.rd});
    end
    if (e.valid && !e.ill) begin
      n_cmp++;
      if ({d.pc, d.rs1d, d.rs2d, d.imm, d.rs1, d.rs2, d.f3} !==
          {e.pc, e.rs1d, e.rs2d, e.imm, e.rs1, e.rs2, e.f3}) begin
        n_bad++;
        $display("FAIL %s data: got pc=%h rs1d=%h rs2d=%h imm=%h rs1=%0d rs2=%0d f3=%0d required pc=%h rs1d=%h rs2d=%h imm=%h rs1=%0d rs2=%0d f3=%0d",
                 name, d.pc, d.rs1d, d.rs2d, d.imm, d.rs1, d.rs2, d.f3,
                 e.pc, e.rs1d, e.rs2d, e.imm, e.rs1, e.rs2, e.f3);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic we, input logic [4:0] rd, input logic [31:0] data);
    if_instr = ins; if_pc = pc; flush = fl; wb_we = we; wb_rd = rd; wb_data = data;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 0) return 32'd0;
    if (we && wrd == r) return wd;
    return mdl_rf[r];
  endfunction

  function automatic void mdl_uses(input logic [31:0] ins, output logic u1, output logic u2);
    logic [6:0] op;
    op = ins[6:0];
    u1 = (op == 7'h67) || (op == 7'h63) || (op == 7'h03) || (op == 7'h23) ||
         (op == 7'h13) || (op == 7'h33);
    u2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  function automatic ex_t mdl_decode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] v1, input logic [31:0] v2);
    ex_t e;
    int f3map [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int f3;
    e = '0;
    f3 = int'(ins[14:12]);
    e.pc = pc; e.rs1d = v1; e.rs2d = v2; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.f3 = ins[14:12]; e.valid = 1'b1;
    case (ins[6:0])
      7'h37: begin e.alu = 10; e.si = 1; e.rw = 1; e.imm = ins & 32'hFFFF_F000; end
      7'h17: begin e.sp = 1; e.si = 1; e.rw = 1; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        e.jp = 1; e.rw = 1;
        e.imm = sx(ins[31] * (1 << 20) + ins[19:12] * (1 << 12) + ins[20] * (1 << 11) +
                   ins[30:21] * 2, 21);
      end
      7'h67: begin e.jp = 1; e.rw = 1; e.si = 1; e.imm = sx(ins[31:20], 12); end
      7'h63: begin
        e.alu = 1; e.br = 1;
        e.imm = sx(ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2, 13);
      end
      7'h03: begin e.si = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.imm = sx(ins[31:20], 12); end
      7'h23: begin e.si = 1; e.mw = 1; e.imm = sx(ins[31:25] * 32 + ins[11:7], 12); end
      7'h13: begin
        e.alu = 4'(f3map[f3]);
        if (f3 == 5 && ins[30]) e.alu = 7;
        e.si = 1; e.rw = 1; e.imm = sx(ins[31:20], 12);
      end
      7'h33: begin
        e.alu = 4'(f3map[f3]);
        if (f3 == 5 && ins[30]) e.alu = 7;
        if (f3 == 0 && ins[30]) e.alu = 1;
        e.rw = 1;
      end
      default: e.ill = 1;
    endcase
    e.rd = e.rw ? ins[11:7] : 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                             7'h33, 7'h7F};
    logic [31:0] ins;
    int k;
    k = $urandom_range(0, 10);
    if (k == 10) return 32'd0;
    ins = $urandom;
    ins[6:0]   = ops[k];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  vec_t tbl [20];

  localparam logic [31:0] I_LW_X3  = 32'h0000A183;  // lw   x3,0(x1)
  localparam logic [31:0] I_ADD_X4 = 32'h00218233;  // add  x4,x3,x2

  initial begin
    ex_t  mex, nxt, bub, ill_e;
    logic [31:0] cur, pc;
    logic hold, st, u1, u2, fl, we;
    logic [4:0] wrd;
    logic [31:0] wd, v1, v2;

    tbl[0]  = '{32'hFFD08113, 32'hFFFFFFFD, 4'd0,  8'b1000_1000, 5'd2,  1'b1, 1'b0}; // addi
    tbl[1]  = '{32'h123452B7, 32'h12345000, 4'd10, 8'b1000_1000, 5'd5,  1'b1, 1'b0}; // lui
    tbl[2]  = '{32'hFFFFF317, 32'hFFFFF000, 4'd0,  8'b1100_1000, 5'd6,  1'b1, 1'b0}; // auipc
    tbl[3]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 4'd0,  8'b0000_1001, 5'd1,  1'b1, 1'b0}; // jal
    tbl[4]  = '{32'h008100E7, 32'h00000008, 4'd0,  8'b1000_1001, 5'd1,  1'b1, 1'b0}; // jalr
    tbl[5]  = '{32'hFE208CE3, 32'hFFFFFFF8, 4'd1,  8'b0000_0010, 5'd0,  1'b1, 1'b0}; // beq
    tbl[6]  = '{32'h0000A183, 32'h00000000, 4'd0,  8'b1010_1100, 5'd3,  1'b1, 1'b0}; // lw
    tbl[7]  = '{32'h0020A623, 32'h0000000C, 4'd0,  8'b1001_0000, 5'd0,  1'b1, 1'b0}; // sw
    tbl[8]  = '{32'h40628233, 32'h00000000, 4'd1,  8'b0000_1000, 5'd4,  1'b1, 1'b0}; // sub
    tbl[9]  = '{32'h4062D233, 32'h00000000, 4'd7,  8'b0000_1000, 5'd4,  1'b1, 1'b0}; // sra
    tbl[10] = '{32'h40345393, 32'h00000403, 4'd7,  8'b1000_1000, 5'd7,  1'b1, 1'b0}; // srai
    tbl[11] = '{32'h00345393, 32'h00000003, 4'd6,  8'b1000_1000, 5'd7,  1'b1, 1'b0}; // srli
    tbl[12] = '{32'hFFF0C493, 32'hFFFFFFFF, 4'd5,  8'b1000_1000, 5'd9,  1'b1, 1'b0}; // xori
    tbl[13] = '{32'h0020B533, 32'h00000000, 4'd4,  8'b0000_1000, 5'd10, 1'b1, 1'b0}; // sltu
    tbl[14] = '{32'h0020F5B3, 32'h00000000, 4'd9,  8'b0000_1000, 5'd11, 1'b1, 1'b0}; // and
    tbl[15] = '{32'hFFFFFFFF, 32'h00000000, 4'd0,  8'b0000_0000, 5'd0,  1'b1, 1'b1}; // illegal
    tbl[16] = '{32'h00000000, 32'h00000000, 4'd0,  8'b0000_0000, 5'd0,  1'b0, 1'b0}; // bubble
    tbl[17] = '{32'h00209633, 32'h00000000, 4'd2,  8'b0000_1000, 5'd12, 1'b1, 1'b0}; // sll
    tbl[18] = '{32'h0050A693, 32'h00000005, 4'd3,  8'b1000_1000, 5'd13, 1'b1, 1'b0}; // slti
    tbl[19] = '{32'h7FF0E713, 32'h000007FF, 4'd8,  8'b1000_1000, 5'd14, 1'b1, 1'b0}; // ori

    bub = '0;
    ill_e = '0; ill_e.valid = 1'b1; ill_e.ill = 1'b1;

    // reset state
    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #12;
    chk_zero("reset_ex");
    chk("reset_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;

    // first edge after reset decodes normally; write x1=5 alongside
    drive(32'h123452B7, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5);
    step();
    chk("first_edge_alu", {28'd0, ex_alu_op}, 32'd10);
    chk("first_edge_valid", {31'd0, ex_valid}, 32'd1);
    chk("first_edge_imm", ex_imm, 32'h12345000);

    // ADDI x2,x1,-3
    drive(32'hFFD08113, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("addi_rs1d", ex_rs1_data, 32'd5);
    chk("addi_imm", ex_imm, 32'hFFFFFFFD);
    chk("addi_ctl", {ex_alu_op, ex_alu_src_imm, ex_reg_write, ex_rd}, {4'd0, 1'b1, 1'b1, 5'd2});
    chk("addi_pc", ex_pc, 32'h100);

    // load-use: exactly one stall cycle
    drive(I_LW_X3, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("lu_load_in_ex", {ex_mem_read, ex_rd}, {1'b1, 5'd3});
    drive(I_ADD_X4, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 chk("lu_stall_on", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    step();
    chk("lu_issue", {ex_valid, ex_rs1, ex_rd}, {1'b1, 5'd3, 5'd4});

    // load followed by formats whose unused source fields equal the load rd
    drive(I_LW_X3, 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    drive(32'h00308293, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0);   // addi x5,x1,3
    #1 chk("nohaz_itype_rs2", {31'd0, stall}, 32'd0);
    drive(I_LW_X3, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    drive(32'h00018337, 32'h114, 1'b0, 1'b0, 5'd0, 32'd0);   // lui, rs1 field = 3
    #1 chk("nohaz_lui_rs1", {31'd0, stall}, 32'd0);
    step();

    // bypass of a same-cycle write-back
    drive(32'd0, 32'h0, 1'b0, 1'b1, 5'd7, 32'h11111111);
    step();
    drive(32'h00038413, 32'h200, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);  // addi x8,x7,0
    step();
    chk("bypass_rs1d", ex_rs1_data, 32'hDEADBEEF);
    drive(32'h00038413, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("rf_written", ex_rs1_data, 32'hDEADBEEF);

    // flush beats stall
    drive(I_LW_X3, 32'h300, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    drive(I_ADD_X4, 32'h304, 1'b1, 1'b0, 5'd0, 32'd0);
    #1 chk("flush_stall", {31'd0, stall}, 32'd0);
    step();
    cmp_ex("flush_bubble", bub);

    // x0 write ignored, illegal opcode
    drive(32'hFFFFFFFF, 32'h400, 1'b0, 1'b1, 5'd0, 32'h1234);
    step();
    cmp_ex("illegal", ill_e);
    drive(32'h000002B3, 32'h404, 1'b0, 1'b1, 5'd0, 32'h1234);     // add x5,x0,x0
    step();
    chk("x0_read", ex_rs1_data | ex_rs2_data, 32'd0);

    // vector table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].ins, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'd0);
      step();
      n_cmp++;
      if ({ex_alu_op, ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, ex_branch, ex_jump, ex_rd, ex_valid, ex_illegal} !==
          {tbl[i].alu, tbl[i].ctl, tbl[i].rd, tbl[i].valid, tbl[i].ill}) begin
        n_bad++;
        $display("FAIL vec%0d ctl: got alu=%0d ctl=%b rd=%0d v=%b i=%b required alu=%0d ctl=%b rd=%0d v=%b i=%b",
                 i, ex_alu_op, {ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write,
                 ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump}, ex_rd, ex_valid, ex_illegal,
                 tbl[i].alu, tbl[i].ctl, tbl[i].rd, tbl[i].valid, tbl[i].ill);
      end
      if (tbl[i].valid && !tbl[i].ill) chk($sformatf("vec%0d_imm", i), ex_imm, tbl[i].imm);
    end

    // reset in the middle of a stall
    drive(I_LW_X3, 32'h500, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    drive(I_ADD_X4, 32'h504, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 chk("rst_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid_ex");
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;
    drive(32'h00038413, 32'h600, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("rst_rf_cleared", ex_rs1_data, 32'd0);

    // randomized run from a fresh reset
    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) mdl_rf[r] = 32'd0;
    mex = '0; hold = 1'b0; cur = 32'd0; pc = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        cur = gen_instr();
        pc  = $urandom;
      end
      fl  = ($urandom_range(0, 9) == 0);
      we  = 1'($urandom_range(0, 1));
      wrd = 5'($urandom_range(0, 3));
      wd  = $urandom;
      drive(cur, pc, fl, we, wrd, wd);
      v1 = mdl_read(cur[19:15], we, wrd, wd);
      v2 = mdl_read(cur[24:20], we, wrd, wd);
      mdl_uses(cur, u1, u2);
      st = !fl && mex.mr && (mex.rd != 0) &&
           ((u1 && mex.rd == cur[19:15]) || (u2 && mex.rd == cur[24:20]));
      #1 chk("rnd_stall", {31'd0, stall}, {31'd0, st});
      nxt = (fl || st || cur == 32'd0) ? bub : mdl_decode(cur, pc, v1, v2);
      if (we && wrd != 0) mdl_rf[wrd] = wd;
      step();
      cmp_ex("rnd_ex", nxt);
      mex  = nxt;
      hold = st;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter REG_BYPASS, default 1, meaning a same-cycle write-back to a source register is forwarded to its read (0 = no forwarding).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have ports if_pc and if_instr, input, 32 each, PC and registered instruction from fetch; instruction 0 = bubble.
REQ-005 SHALL have port flush, input, 1, meaning a taken branch/jump was resolved in EX and the instruction now in ID is killed.
REQ-006 SHALL have ports wb_we (1), wb_rd (5) and wb_data (32), inputs, the register-file write port from WB.
REQ-007 SHALL have port stall, output, 1, combinational load-use hazard request to fetch (hold PC and instruction).
REQ-008 SHALL have registered ID/EX outputs ex_pc (32), ex_rs1_data (32), ex_rs2_data (32), ex_imm (32), ex_rs1 (5), ex_rs2 (5), ex_rd (5), ex_funct3 (3) and ex_alu_op (4).
REQ-009 SHALL have registered 1-bit ID/EX outputs ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump, ex_valid and ex_illegal.

Function
REQ-010 SHALL hold a 32x32 register file in which x0 always reads 0, writes to x0 are ignored, and a write occurs on the rising edge of clk when wb_we=1.
REQ-011 SHALL read rs1=instr[19:15] and rs2=instr[24:20] combinationally; when REG_BYPASS=1, wb_we=1, wb_rd equals the source and the source is nonzero, the read SHALL return wb_data.
REQ-012 SHALL generate sign-extended immediates in I, S, B (bit0=0), U (low 12 bits zero) and J (bit0=0) formats, with ex_imm=0 for R-type.
REQ-013 SHALL decode instructions as follows:
- LUI: alu_op=PASSB, src_imm, reg_write.
- AUIPC: ADD, src_pc, src_imm, reg_write.
- JAL/JALR: jump, reg_write; JALR additionally src_imm.
- BRANCH: SUB, branch.
- LOAD: ADD, src_imm, mem_read, mem_to_reg, reg_write.
- STORE: ADD, src_imm, mem_write.
- OP-IMM/OP: ALU operation from funct3/funct7[5]; SUB and SRA are distinguished by funct7[5]; SRAI by imm[10].
REQ-014 SHALL encode alu_op as ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
REQ-015 SHALL pass funct3=instr[14:12] through to ex_funct3 for every valid instruction.
REQ-016 SHALL treat an unknown opcode as illegal: all control outputs 0, ex_valid=1, ex_illegal=1.
REQ-017 SHALL treat if_instr=0 as a bubble: all control outputs 0, ex_valid=0, ex_illegal=0.
REQ-018 SHALL assert stall when all of the following hold:
- ex_mem_read=1 and ex_rd is nonzero;
- ex_rd matches an rs1 or rs2 that the current format actually reads (rs1 is unused by LUI, AUIPC and JAL; rs2 is used only by OP, STORE and BRANCH);
- flush=0.
REQ-019 SHALL load a bubble into ID/EX on an edge where stall=1, then decode the same held instruction on the next edge, giving exactly one stall cycle per load-use.
REQ-020 SHALL load a bubble into ID/EX on an edge where flush=1; flush takes precedence over stall and forces stall=0.
REQ-021 SHALL otherwise capture the decoded instruction into ID/EX every cycle, with one cycle of latency from if_instr to the ex_* outputs.
REQ-022 SHALL zero ex_rd when reg_write=0 so that downstream hazard and forwarding logic never matches stale destinations.

Reset
REQ-023 SHALL, while rst=1, asynchronously drive every ex_* output and all 32 register-file entries to 0, with stall=0 as a consequence.
REQ-024 SHALL leave the first edge after rst deasserts decoding if_instr normally.

Verification
REQ-025 SHALL pass the ADDI scenario: wb writes x1=5; if_instr=ADDI x2,x1,-3 (0xFFD08113) -> next cycle ex_rs1_data=5, ex_imm=0xFFFFFFFD, alu_op=0, src_imm=1, reg_write=1, ex_rd=2.
REQ-026 SHALL pass the load-use scenario: LW x3,0(x1) then ADD x4,x3,x2 -> stall=1 for one cycle, a bubble (ex_valid=0) enters EX, then the ADD issues with ex_rs1=3 and stall=0.
REQ-027 SHALL pass the bypass scenario: same cycle wb_we=1, wb_rd=7, wb_data=0xDEADBEEF and if_instr reads x7 -> ex_rs1_data=0xDEADBEEF.
REQ-028 SHALL pass the flush-over-stall scenario: flush=1 during a load-use hazard -> stall=0 and all ex_* controls are 0 next cycle.
REQ-029 SHALL pass the x0/illegal scenario: wb write to x0 of 0x1234 and if_instr=0xFFFFFFFF -> x0 still reads 0, next cycle ex_illegal=1 with controls 0.
REQ-030 SHALL pass the mid-operation reset scenario: rst asserted during a stall -> all ex_* outputs are 0 immediately and stall=0.
